// File: rtl/huffman_pkg.sv
// Shared Huffman definitions: default table geometry, decoder state encoding
// and the packed table payloads exchanged with descendSort and the encoder.
package huffman_pkg;

    localparam int unsigned NSYM_DEF   = 8;
    localparam int unsigned SYMW_DEF   = 8;
    localparam int unsigned MAXLEN_DEF = NSYM_DEF - 1;
    localparam int unsigned CNTW_DEF   = $clog2(NSYM_DEF + 1);

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        DECODE = 2'd1,
        EMIT   = 2'd2,
        ERR    = 2'd3
    } state_t;

    // Index 0 is the most probable symbol / the count of length-1 codes.
    typedef logic [NSYM_DEF-1:0][SYMW_DEF-1:0]   sym_tab_t;
    typedef logic [MAXLEN_DEF-1:0][CNTW_DEF-1:0] cnt_tab_t;

endpackage

// File: rtl/huffman_canon_step.sv
// One bit of canonical Huffman decoding: folds bit_in into the running code,
// tests it against the current length's code range and computes the advance.
module huffman_canon_step
    import huffman_pkg::*;
#(
    parameter int unsigned MAXLEN = MAXLEN_DEF,
    parameter int unsigned CNTW   = CNTW_DEF,
    parameter int unsigned IDXW   = $clog2(NSYM_DEF) + 1
) (
    input  logic [MAXLEN:0] code,
    input  logic [MAXLEN:0] first,
    input  logic [IDXW-1:0] index,
    input  logic [CNTW-1:0] cnt,
    input  logic            bit_in,
    output logic            match_c,
    output logic [IDXW-1:0] sym_idx_c,
    output logic [MAXLEN:0] code_next_c,
    output logic [MAXLEN:0] first_next_c,
    output logic [IDXW-1:0] index_next_c
);

    localparam int unsigned CODEW = MAXLEN + 1;

    logic [CODEW-1:0] c;
    logic [CODEW-1:0] diff;
    logic [CODEW-1:0] cnt_ext;

    // A code below first would wrap in the subtraction, so reject it explicitly.
    always_comb begin
        c            = CODEW'({code, bit_in});
        cnt_ext      = CODEW'(cnt);
        diff         = c - first;
        match_c      = (c >= first) && (diff < cnt_ext);
        sym_idx_c    = index + IDXW'(diff);
        code_next_c  = c;
        first_next_c = (first + cnt_ext) << 1;
        index_next_c = index + IDXW'(cnt);
    end

endmodule

// File: rtl/huffman_decoder.sv
// Canonical Huffman decoder: loads a symbol/count table, consumes one code bit
// per handshake and emits one symbol per completed codeword.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int unsigned NSYM   = NSYM_DEF,
    parameter int unsigned SYMW   = SYMW_DEF,
    parameter int unsigned MAXLEN = MAXLEN_DEF,
    parameter int unsigned CNTW   = CNTW_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_load,
    input  logic [NSYM*SYMW-1:0]   cfg_sym,
    input  logic [MAXLEN*CNTW-1:0] cfg_cnt,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic [SYMW-1:0]        sym_out,
    output logic                   sym_valid,
    input  logic                   sym_ready,
    output logic                   err
);

    localparam int unsigned CODEW = MAXLEN + 1;
    localparam int unsigned IDXW  = $clog2(NSYM) + 1;
    localparam int unsigned LENW  = $clog2(MAXLEN + 1);

    state_t                 state_q, state_d;
    logic [CODEW-1:0]       code_q, code_d;
    logic [CODEW-1:0]       first_q, first_d;
    logic [IDXW-1:0]        index_q, index_d;
    logic [LENW-1:0]        len_q, len_d;
    logic [NSYM*SYMW-1:0]   sym_tab_q, sym_tab_d;
    logic [MAXLEN*CNTW-1:0] cnt_tab_q, cnt_tab_d;
    logic [SYMW-1:0]        sym_out_d;
    logic                   bit_ready_d;
    logic                   sym_valid_d;
    logic                   err_d;

    logic [CNTW-1:0]        cnt_cur;
    logic [SYMW-1:0]        sym_sel;
    logic                   match_c;
    logic [IDXW-1:0]        sym_idx_c;
    logic [CODEW-1:0]       code_next_c;
    logic [CODEW-1:0]       first_next_c;
    logic [IDXW-1:0]        index_next_c;

    // Code count for the current codeword length.
    always_comb begin
        cnt_cur = '0;
        for (int l = 0; l < int'(MAXLEN); l++) begin
            if (len_q == LENW'(l + 1)) cnt_cur = cnt_tab_q[l*CNTW +: CNTW];
        end
    end

    huffman_canon_step #(
        .MAXLEN (MAXLEN),
        .CNTW   (CNTW),
        .IDXW   (IDXW)
    ) u_step (
        .code         (code_q),
        .first        (first_q),
        .index        (index_q),
        .cnt          (cnt_cur),
        .bit_in       (bit_in),
        .match_c      (match_c),
        .sym_idx_c    (sym_idx_c),
        .code_next_c  (code_next_c),
        .first_next_c (first_next_c),
        .index_next_c (index_next_c)
    );

    // Table lookup; out-of-range indices from an inconsistent table read as zero.
    always_comb begin
        sym_sel = '0;
        for (int i = 0; i < int'(NSYM); i++) begin
            if (sym_idx_c == IDXW'(i)) sym_sel = sym_tab_q[i*SYMW +: SYMW];
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        first_d   = first_q;
        index_d   = index_q;
        len_d     = len_q;
        sym_tab_d = sym_tab_q;
        cnt_tab_d = cnt_tab_q;
        sym_out_d = sym_out;
        err_d     = err;

        if (cfg_load) begin
            sym_tab_d = cfg_sym;
            cnt_tab_d = cfg_cnt;
            code_d    = '0;
            first_d   = '0;
            index_d   = '0;
            len_d     = LENW'(1);
            err_d     = 1'b0;
            state_d   = DECODE;
        end else begin
            case (state_q)
                DECODE: begin
                    if (bit_valid && bit_ready) begin
                        if (match_c) begin
                            sym_out_d = sym_sel;
                            state_d   = EMIT;
                        end else if (len_q == LENW'(MAXLEN)) begin
                            err_d   = 1'b1;
                            state_d = ERR;
                        end else begin
                            code_d  = code_next_c;
                            first_d = first_next_c;
                            index_d = index_next_c;
                            len_d   = len_q + LENW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (sym_ready) begin
                        code_d  = '0;
                        first_d = '0;
                        index_d = '0;
                        len_d   = LENW'(1);
                        state_d = DECODE;
                    end
                end
                default: ;
            endcase
        end

        // Handshake flags follow the state being entered so they stay registered.
        bit_ready_d = (state_d == DECODE);
        sym_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= UNCFG;
            code_q    <= '0;
            first_q   <= '0;
            index_q   <= '0;
            len_q     <= '0;
            sym_tab_q <= '0;
            cnt_tab_q <= '0;
            sym_out   <= '0;
            bit_ready <= 1'b0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            first_q   <= first_d;
            index_q   <= index_d;
            len_q     <= len_d;
            sym_tab_q <= sym_tab_d;
            cnt_tab_q <= cnt_tab_d;
            sym_out   <= sym_out_d;
            bit_ready <= bit_ready_d;
            sym_valid <= sym_valid_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: codebook-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_huffman_decoder;

    localparam int unsigned NSYM   = 8;
    localparam int unsigned SYMW   = 8;
    localparam int unsigned MAXLEN = 7;
    localparam int unsigned CNTW   = 4;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   cfg_load;
    logic [NSYM*SYMW-1:0]   cfg_sym;
    logic [MAXLEN*CNTW-1:0] cfg_cnt;
    logic                   bit_in;
    logic                   bit_valid;
    logic                   bit_ready;
    logic [SYMW-1:0]        sym_out;
    logic                   sym_valid;
    logic                   sym_ready;
    logic                   err;

    huffman_decoder #(
        .NSYM(NSYM), .SYMW(SYMW), .MAXLEN(MAXLEN), .CNTW(CNTW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_load  (cfg_load),
        .cfg_sym   (cfg_sym),
        .cfg_cnt   (cfg_cnt),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .err       (err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Tables: index 0 is the most probable symbol / count of length-1 codes.
    int syms_a  [NSYM]   = '{44, 25, 10, 6, 5, 4, 3, 2};
    int cnt_a   [MAXLEN] = '{1, 1, 1, 1, 1, 1, 2};
    int cnt_b   [MAXLEN] = '{0, 2, 2, 4, 0, 0, 0};
    int cnt_bad [MAXLEN] = '{1, 0, 0, 0, 0, 0, 0};
    int cnt_c   [MAXLEN] = '{1, 1, 1, 0, 0, 0, 0};
    int cur_syms [NSYM];
    int cur_cnt  [MAXLEN];

    // Reference model: explicit codebook, bits gathered until one entry matches.
    int cb_len  [NSYM];
    int cb_code [NSYM];
    int cb_sym  [NSYM];
    int m_mode = 0;      // 0 unconfigured, 1 taking bits, 2 holding symbol, 3 error
    int m_bits = 0;
    int m_nb   = 0;
    int m_err  = 0;
    int m_sym  = 0;
    int m_hit;
    int mq [$];          // symbols handed to the sink, in order

    function automatic void build_cb(input logic [NSYM*SYMW-1:0] s,
                                     input logic [MAXLEN*CNTW-1:0] c);
        int code;
        int k;
        int n;
        code = 0;
        k    = 0;
        for (int i = 0; i < int'(NSYM); i++) begin
            cb_len[i]  = 0;
            cb_code[i] = 0;
            cb_sym[i]  = int'(s[i*SYMW +: SYMW]);
        end
        for (int l = 1; l <= int'(MAXLEN); l++) begin
            n = int'(c[(l-1)*CNTW +: CNTW]);
            for (int j = 0; j < n; j++) begin
                if (k < int'(NSYM)) begin
                    cb_len[k]  = l;
                    cb_code[k] = code;
                    k++;
                end
                code++;
            end
            code = code * 2;
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_mode = 0; m_bits = 0; m_nb = 0; m_err = 0; m_sym = 0;
        end else if (cfg_load) begin
            build_cb(cfg_sym, cfg_cnt);
            m_mode = 1; m_bits = 0; m_nb = 0; m_err = 0;
        end else if (m_mode == 1 && bit_valid) begin
            m_bits = m_bits * 2 + int'(bit_in);
            m_nb++;
            m_hit = -1;
            for (int s = 0; s < int'(NSYM); s++)
                if (cb_len[s] == m_nb && cb_code[s] == m_bits) m_hit = s;
            if (m_hit >= 0) begin
                m_sym  = cb_sym[m_hit];
                m_mode = 2;
            end else if (m_nb == int'(MAXLEN)) begin
                m_err  = 1;
                m_mode = 3;
            end
        end else if (m_mode == 2 && sym_ready) begin
            mq.push_back(m_sym);
            m_mode = 1; m_bits = 0; m_nb = 0;
        end
    end

    // Per-cycle comparison of DUT outputs with the model.
    logic cmp_en = 1'b0;
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("bit_ready", int'(bit_ready), int'(m_mode == 1));
            chk("sym_valid", int'(sym_valid), int'(m_mode == 2));
            chk("err", int'(err), m_err);
            if (m_mode == 2) chk("sym_out", int'(sym_out), m_sym);
        end
    end

    // Sink readiness: fixed level or random back-pressure.
    logic rand_ready = 1'b0;
    logic ready_val  = 1'b1;
    always @(negedge clock) sym_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_val;

    function automatic int q_at(input int i);
        return (i < mq.size()) ? mq[i] : -1;
    endfunction

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic do_load();
        for (int i = 0; i < int'(NSYM); i++) cfg_sym[i*SYMW +: SYMW] = SYMW'(cur_syms[i]);
        for (int l = 0; l < int'(MAXLEN); l++) cfg_cnt[l*CNTW +: CNTW] = CNTW'(cur_cnt[l]);
        cfg_load = 1'b1;
        @(negedge clock);
        cfg_load = 1'b0;
    endtask

    // Offer one bit and return on the negedge after it is taken (or on err).
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && !err && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL bit_accept_timeout: got bit_ready=0 expected 1 at %0t", $time);
        end
        if (bit_ready) @(negedge clock);
        bit_valid = 1'b0;
    endtask

    task automatic send_pattern(input int val, input int nbits);
        for (int b = nbits - 1; b >= 0; b--) send_bit(1'((val >> b) & 1));
    endtask

    task automatic send_code(input int s);
        for (int b = cb_len[s] - 1; b >= 0; b--) begin
            if ($urandom_range(0, 3) == 0) begin
                bit_in = 1'($urandom);
                idle($urandom_range(1, 2));
            end
            send_bit(1'((cb_code[s] >> b) & 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int sent;
        reset = 1'b1; cfg_load = 1'b0; cfg_sym = '0; cfg_cnt = '0;
        bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
        repeat (5) @(negedge clock);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Unconfigured: nothing accepted, nothing emitted.
        chk("rst_bit_ready", int'(bit_ready), 0);
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sym_out", int'(sym_out), 0);
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            @(negedge clock);
            chk("uncfg_bit_ready", int'(bit_ready), 0);
            chk("uncfg_sym_valid", int'(sym_valid), 0);
        end
        idle(1);

        // Short codes back to back: 0, 10, 110.
        cur_syms = syms_a; cur_cnt = cnt_a;
        do_load();
        mq.delete();
        send_bit(1'b0);
        chk("lat_44_valid", int'(sym_valid), 1);
        chk("lat_44_value", int'(sym_out), 44);
        send_pattern(2, 2);
        chk("lat_25_valid", int'(sym_valid), 1);
        send_pattern(6, 3);
        chk("lat_10_valid", int'(sym_valid), 1);
        idle(2);
        chk("seq_count", mq.size(), 3);
        chk("seq0", q_at(0), 44);
        chk("seq1", q_at(1), 25);
        chk("seq2", q_at(2), 10);

        // Longest codes.
        mq.delete();
        send_pattern(7'b1111110, 7);
        send_pattern(7'b1111111, 7);
        idle(2);
        chk("long0", q_at(0), 3);
        chk("long1", q_at(1), 2);
        chk("long_err", int'(err), 0);

        // Sink stall: symbol held, offered bit not consumed.
        mq.delete();
        ready_val = 1'b0;
        idle(2);
        send_pattern(6, 3);
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_sym_out", int'(sym_out), 10);
            chk("stall_sym_valid", int'(sym_valid), 1);
            chk("stall_bit_ready", int'(bit_ready), 0);
            @(negedge clock);
        end
        chk("stall_nothing_taken", mq.size(), 0);
        ready_val = 1'b1;
        send_bit(1'b0);
        idle(2);
        chk("stall_first", q_at(0), 10);
        chk("stall_next", q_at(1), 44);

        // Table with only code 0: seven ones is an invalid codeword.
        cur_cnt = cnt_bad;
        do_load();
        send_pattern(7'b1111111, 7);
        chk("bad_err", int'(err), 1);
        chk("bad_bit_ready", int'(bit_ready), 0);
        idle(3);
        chk("bad_err_sticky", int'(err), 1);
        cur_cnt = cnt_a;
        do_load();
        chk("reload_err_clear", int'(err), 0);
        mq.delete();
        send_bit(1'b0);
        idle(2);
        chk("recover_sym", q_at(0), 44);

        // Reset in the middle of a codeword.
        send_pattern(3, 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_bit_ready", int'(bit_ready), 0);
        do_load();
        mq.delete();
        send_bit(1'b0);
        idle(2);
        chk("midrst_sym", q_at(0), 44);

        // Reload in the middle of a codeword.
        send_pattern(3, 2);
        do_load();
        mq.delete();
        send_bit(1'b0);
        idle(2);
        chk("midload_sym", q_at(0), 44);

        // Random tables, symbols, gaps and back-pressure.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < int'(NSYM); i++) cur_syms[i] = int'($urandom_range(0, 255));
            cur_cnt = (t % 2 == 1) ? cnt_a : cnt_b;
            do_load();
            mq.delete();
            rand_ready = 1'b1;
            sent = 0;
            for (int k = 0; k < 40; k++) begin
                send_code(int'($urandom_range(0, NSYM - 1)));
                sent++;
            end
            rand_ready = 1'b0;
            ready_val  = 1'b1;
            idle(6);
            chk("rand_count", mq.size(), sent);
        end

        // Random bits into an incomplete table until the decoder gives up.
        cur_cnt = cnt_c;
        do_load();
        rand_ready = 1'b1;
        for (int k = 0; k < 80 && !err; k++) send_bit(1'($urandom));
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        idle(4);

        cur_cnt = cnt_a;
        cur_syms = syms_a;
        do_load();
        mq.delete();
        send_pattern(2, 2);
        idle(2);
        chk("final_sym", q_at(0), 25);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
Canonical Huffman decoder, the receive-side counterpart to the encode path built around descendSort. Loads a code table (symbols in descending-probability order plus per-length code counts), then consumes a serial bitstream one bit per handshake and emits one decoded symbol per codeword. Sits between the bit deserializer and the symbol sink.

Parameters:
NSYM, 8, number of symbols in the table
SYMW, 8, symbol width in bits
MAXLEN, 7, maximum codeword length (NSYM-1)
CNTW, 4, per-length count width, $clog2(NSYM+1)

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_load  in  1  one-cycle strobe: capture cfg_sym/cfg_cnt
cfg_sym  in  NSYM*SYMW  symbols, index 0 = most probable (descendSort output order)
cfg_cnt  in  MAXLEN*CNTW  cfg_cnt[L-1] = number of codes of length L
bit_in  in  1  serial code bit, MSB of codeword first
bit_valid  in  1  bit_in valid
bit_ready  out  1  decoder accepts a bit this cycle
sym_out  out  SYMW  decoded symbol
sym_valid  out  1  sym_out valid
sym_ready  in  1  sink accepts sym_out
err  out  1  sticky: invalid codeword (no match within MAXLEN bits)

Behaviour:
- Reset: state UNCFG; table, code, first, index, len cleared; bit_ready=0, sym_valid=0, sym_out=0, err=0. Reset wins over every other input.
- States: UNCFG, DECODE, EMIT, ERR.
- cfg_load (any state): register table next edge, clear code/first/index, len=1, err=0, go DECODE. Partial codeword or pending symbol discarded.
- DECODE: bit_ready=1. On bit_valid&&bit_ready (one step per accepted bit):
  c = (code<<1)|bit_in; if c-first < cnt[len]: sym_out <= sym[index + c-first], go EMIT;
  else index += cnt[len], first = (first+cnt[len])<<1, code = c, len++.
  If no match and len==MAXLEN: err<=1, go ERR.
- Width rules: code/first MAXLEN+1 bits unsigned, index $clog2(NSYM)+1 bits; subtraction compare unsigned (c<first treated as no match).
- Latency: sym_valid asserts the cycle after the last code bit is accepted.
- EMIT: bit_ready=0, sym_valid=1, sym_out stable until sym_valid&&sym_ready; then clear code/first/index, len=1, return DECODE (next bit accepted the following cycle). Max throughput: one symbol per (codelen+1) cycles.
- ERR: bit_ready=0, sym_valid=0, err=1; exit only by reset or cfg_load.
- UNCFG: bit_ready=0; bits ignored.
- Table consistency (Kraft sum) is the loader's responsibility; unused codes produce err.

Decomposition:
- huffman_pkg: NSYM, SYMW, MAXLEN, CNTW defaults, state enum (UNCFG/DECODE/EMIT/ERR), packed typedefs sym_tab_t and cnt_tab_t shared with descendSort and the encoder.
- One sub-module natural: huffman_canon_step (combinational one-bit canonical compare/advance: code, first, index, cnt -> match, sym_idx, next code/first/index). FSM and registers stay in huffman_decoder.

Test Plan:
Shared table: cfg_sym = {44,25,10,6,5,4,3,2}, cfg_cnt L1..L7 = {1,1,1,1,1,1,2}; codes 0,10,110,1110,11110,111110,1111110,1111111.
- Reset held 5 cycles then released, no cfg_load -> bit_ready=0, sym_valid=0, err=0, bits ignored.
- Load table, stream 0,1,0,1,1,0, sym_ready=1 -> symbols 44,25,10 in order, each sym_valid one cycle after its last bit.
- Stream 1111110 then 1111111 -> 3 then 2; err stays 0.
- Code 110 with sym_ready low 3 cycles -> sym_out=10 held stable, bit_ready=0 throughout, bit_valid bits not consumed; next symbol decodes correctly after accept.
- Load cfg_cnt = {1,0,0,0,0,0,0}, stream 1111111 -> err=1 after 7th bit, state ERR, bit_ready=0; cfg_load of good table clears err, stream 0 -> 44.
- Mid-codeword (bits 1,1 accepted) assert reset one cycle, reload table, stream 0 -> 44 (no stale partial code); same with cfg_load instead of reset -> 44.
